// File: rtl/next_pc_gen.sv
// next_pc_gen: computes the next instruction address for the KGP-RISC PC
// register from the committed PC and the resolved control-flow request.
// The result is registered, so it appears one cycle after the request.
//
// Build option: define NPC_RAS_EN to include the return-address stack.
// Without it, CALL acts as JUMP_IMM, RET acts as JUMP_REG using target_reg,
// and ras_ovf/ras_unf stay at 0.
module next_pc_gen #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  input  logic        req_valid,
  input  logic [2:0]  req_type,
  input  logic        cond_flag,
  input  logic [31:0] offset,
  input  logic [31:0] target_reg,
  input  logic        stall,
  output logic [31:0] next_pc,
  output logic        next_valid,
  output logic        halted,
  output logic        misalign,
  output logic        ras_ovf,
  output logic        ras_unf
);

  // Request encodings; 7 is reserved and falls into the sequential default.
  localparam logic [2:0] REQ_SEQ  = 3'd0;
  localparam logic [2:0] REQ_BR   = 3'd1;
  localparam logic [2:0] REQ_JIMM = 3'd2;
  localparam logic [2:0] REQ_JREG = 3'd3;
  localparam logic [2:0] REQ_CALL = 3'd4;
  localparam logic [2:0] REQ_RET  = 3'd5;
  localparam logic [2:0] REQ_HALT = 3'd6;

  if (RAS_DEPTH < 2 || RAS_DEPTH > 32 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("next_pc_gen: RAS_DEPTH must be a power of 2 in the range 2..32");
  end

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic        misalign_q, misalign_d;

  logic        accept;
  logic [31:0] s4;
  logic [31:0] rel_tgt;
  logic [31:0] ret_tgt;
  logic [31:0] raw_tgt;

  // A request only counts in RUN with the downstream ready.
  assign accept  = (state_q == ST_RUN) && req_valid && !stall;
  assign s4      = pc_cur + 32'd4;
  assign rel_tgt = s4 + offset;

`ifdef NPC_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

  // Stack storage is data only; its validity is tracked by cnt_q.
  logic [31:0]      ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rd_idx;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             ras_empty, ras_full;
  logic             push, pop;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  assign push      = accept && (req_type == REQ_CALL);
  assign pop       = accept && (req_type == REQ_RET);
  assign rd_idx    = wp_q - PTR_W'(1);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == (PTR_W + 1)'(RAS_DEPTH));
  // An empty pop falls through to the sequential address.
  assign ret_tgt   = ras_empty ? s4 : ras_mem[rd_idx];

  // Stack pointer, occupancy and sticky overflow/underflow next state.
  always_comb begin
    wp_d  = wp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (push) begin
      // The write pointer wraps, so a full push replaces the oldest entry.
      wp_d = wp_q + PTR_W'(1);
      if (ras_full) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + (PTR_W + 1)'(1);
      end
    end else if (pop) begin
      if (ras_empty) begin
        unf_d = 1'b1;
      end else begin
        wp_d  = rd_idx;
        cnt_d = cnt_q - (PTR_W + 1)'(1);
      end
    end
  end

  // Stack control registers, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage write on CALL; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      ras_mem[wp_q] <= s4;
    end
  end

  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;
`else
  // Without the stack, a return goes through the register target.
  assign ret_tgt = target_reg;
  assign ras_ovf = 1'b0;
  assign ras_unf = 1'b0;
`endif

  // Raw (unaligned) target selection by request type.
  always_comb begin
    raw_tgt = s4;
    case (req_type)
      REQ_SEQ:  raw_tgt = s4;
      REQ_BR:   raw_tgt = cond_flag ? rel_tgt : s4;
      REQ_JIMM: raw_tgt = rel_tgt;
      REQ_JREG: raw_tgt = target_reg;
      REQ_CALL: raw_tgt = rel_tgt;
      REQ_RET:  raw_tgt = ret_tgt;
      REQ_HALT: raw_tgt = s4;
      default:  raw_tgt = s4;
    endcase
  end

  // FSM next state and registered output next values.
  always_comb begin
    state_d    = state_q;
    next_pc_d  = next_pc_q;
    valid_d    = 1'b0;
    halted_d   = halted_q;
    misalign_d = misalign_q;
    case (state_q)
      ST_BOOT: begin
        if (!stall) begin
          next_pc_d = BOOT_ADDR;
          valid_d   = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          next_pc_d = {raw_tgt[31:2], 2'b00};
          valid_d   = 1'b1;
          if (raw_tgt[1:0] != 2'b00) begin
            misalign_d = 1'b1;
          end
          if (req_type == REQ_HALT) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
        end
      end
      ST_HALT: begin
        // Parked until reset; requests are ignored.
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      next_pc_q  <= BOOT_ADDR;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      next_pc_q  <= next_pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
    end
  end

  assign next_pc    = next_pc_q;
  assign next_valid = valid_q;
  assign halted     = halted_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_next_pc_gen.sv
// Directed bench for next_pc_gen with a reference model feeding a scoreboard.
module tb_next_pc_gen;

  localparam logic [31:0] BOOT = 32'h0000_0000;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur;
  logic        req_valid;
  logic [2:0]  req_type;
  logic        cond_flag;
  logic [31:0] offset;
  logic [31:0] target_reg;
  logic        stall;
  logic [31:0] next_pc;
  logic        next_valid;
  logic        halted;
  logic        misalign;
  logic        ras_ovf;
  logic        ras_unf;

  int checks = 0;
  int errors = 0;

  next_pc_gen #(.BOOT_ADDR(BOOT), .RAS_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_cur     (pc_cur),
    .req_valid  (req_valid),
    .req_type   (req_type),
    .cond_flag  (cond_flag),
    .offset     (offset),
    .target_reg (target_reg),
    .stall      (stall),
    .next_pc    (next_pc),
    .next_valid (next_valid),
    .halted     (halted),
    .misalign   (misalign),
    .ras_ovf    (ras_ovf),
    .ras_unf    (ras_unf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        vld;
    logic        hlt;
    logic        mis;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb[$];

  // Reference model state: 0 = boot, 1 = run, 2 = halt.
  int          m_state;
  logic [31:0] m_pc;
  logic        m_vld, m_hlt, m_mis, m_ovf, m_unf;
  logic [31:0] m_ras[$];

  task automatic model_reset();
    m_state = 0;
    m_pc    = BOOT;
    m_vld   = 1'b0;
    m_hlt   = 1'b0;
    m_mis   = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_ras.delete();
  endtask

  task automatic model_step(input logic v, input logic [2:0] t, input logic c,
                            input logic [31:0] off, input logic [31:0] tgt,
                            input logic [31:0] pc, input logic st);
    logic [31:0] s4;
    logic [31:0] raw;
    m_vld = 1'b0;
    if (m_state == 0) begin
      if (!st) begin
        m_pc    = BOOT;
        m_vld   = 1'b1;
        m_state = 1;
      end
    end else if (m_state == 1 && v && !st) begin
      s4  = pc + 32'd4;
      raw = s4;
      if (t == 3'd1 && c) raw = s4 + off;
      if (t == 3'd2) raw = s4 + off;
      if (t == 3'd3) raw = tgt;
      if (t == 3'd4) begin
        raw = s4 + off;
`ifdef NPC_RAS_EN
        if (m_ras.size() == DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
        m_ras.push_back(s4);
`endif
      end
      if (t == 3'd5) begin
`ifdef NPC_RAS_EN
        if (m_ras.size() == 0) begin
          raw   = s4;
          m_unf = 1'b1;
        end else begin
          raw = m_ras.pop_back();
        end
`else
        raw = tgt;
`endif
      end
      if (raw[1:0] != 2'b00) m_mis = 1'b1;
      m_pc  = raw & 32'hFFFF_FFFC;
      m_vld = 1'b1;
      if (t == 3'd6) begin
        m_state = 2;
        m_hlt   = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, push model prediction, compare after the edge.
  // lit_on adds a cross-check of next_pc against a hand-derived constant.
  task automatic cyc(input string tag, input logic v, input logic [2:0] t,
                     input logic c, input logic [31:0] off, input logic [31:0] tgt,
                     input logic [31:0] pc, input logic st,
                     input logic lit_on, input logic [31:0] lit);
    exp_t e;
    req_valid  = v;
    req_type   = t;
    cond_flag  = c;
    offset     = off;
    target_reg = tgt;
    pc_cur     = pc;
    stall      = st;
    model_step(v, t, c, off, tgt, pc, st);
    sb.push_back({m_pc, m_vld, m_hlt, m_mis, m_ovf, m_unf});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".next_pc"},    next_pc,           e.pc);
    chk({tag, ".next_valid"}, {31'd0, next_valid}, {31'd0, e.vld});
    chk({tag, ".halted"},     {31'd0, halted},     {31'd0, e.hlt});
    chk({tag, ".misalign"},   {31'd0, misalign},   {31'd0, e.mis});
    chk({tag, ".ras_ovf"},    {31'd0, ras_ovf},    {31'd0, e.ovf});
    chk({tag, ".ras_unf"},    {31'd0, ras_unf},    {31'd0, e.unf});
    if (lit_on) chk({tag, ".lit"}, next_pc, lit);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".next_pc"},    next_pc,             BOOT);
    chk({tag, ".next_valid"}, {31'd0, next_valid}, 32'd0);
    chk({tag, ".halted"},     {31'd0, halted},     32'd0);
    chk({tag, ".misalign"},   {31'd0, misalign},   32'd0);
    chk({tag, ".ras_ovf"},    {31'd0, ras_ovf},    32'd0);
    chk({tag, ".ras_unf"},    {31'd0, ras_unf},    32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ret_lit;
    rst        = 1'b0;
    pc_cur     = '0;
    req_valid  = 1'b0;
    req_type   = 3'd0;
    cond_flag  = 1'b0;
    offset     = '0;
    target_reg = '0;
    stall      = 1'b0;
    model_reset();

    // Reset state.
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // BOOT held by stall, then released.
    cyc("boot_stall", 1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, BOOT);
    cyc("boot",       1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    cyc("seq0",       1'b1, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h4);

    // Conditional branch, taken and not taken with a negative offset.
    cyc("br_taken", 1'b1, 3'd1, 1'b1, 32'hFFFF_FFF0, 32'h0, 32'h100, 1'b0, 1'b1, 32'hF4);
    cyc("br_not",   1'b1, 3'd1, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h100, 1'b0, 1'b1, 32'h104);
    cyc("jimm",     1'b1, 3'd2, 1'b0, 32'h0000_0020, 32'h0, 32'h180, 1'b0, 1'b1, 32'h1A4);

    // Call and matching return.
    cyc("call", 1'b1, 3'd4, 1'b0, 32'h40, 32'h0, 32'h200, 1'b0, 1'b1, 32'h244);
`ifdef NPC_RAS_EN
    ret_lit = 32'h204;
`else
    ret_lit = 32'h888;
`endif
    cyc("ret", 1'b1, 3'd5, 1'b0, 32'h0, 32'h888, 32'h244, 1'b0, 1'b1, ret_lit);

    // Return with an empty stack.
`ifdef NPC_RAS_EN
    ret_lit = 32'h304;
`else
    ret_lit = 32'h500;
`endif
    cyc("ret_empty", 1'b1, 3'd5, 1'b0, 32'h0, 32'h500, 32'h300, 1'b0, 1'b1, ret_lit);

    // Nine calls overflow an 8-deep stack; nine returns drain and underflow.
    for (int i = 0; i < 9; i++) begin
      cyc($sformatf("call_%0d", i), 1'b1, 3'd4, 1'b0, 32'h100, 32'h0,
          32'h1000 + 32'(i) * 32'h10, 1'b0, 1'b1, 32'h1104 + 32'(i) * 32'h10);
    end
    for (int i = 0; i < 9; i++) begin
      cyc($sformatf("ret_%0d", i), 1'b1, 3'd5, 1'b0, 32'h0, 32'h2000 + 32'(i) * 32'h8,
          32'h3000 + 32'(i) * 32'h10, 1'b0, 1'b0, 32'h0);
    end

    // Idle cycle holds the address.
    cyc("idle", 1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Misaligned register target.
    cyc("jreg_mis", 1'b1, 3'd3, 1'b0, 32'h0, 32'h1003, 32'h40, 1'b0, 1'b1, 32'h1000);

    // Stalled CALL for three cycles: no update and no push.
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("stall_%0d", i), 1'b1, 3'd4, 1'b0, 32'h80, 32'h0, 32'h400,
          1'b1, 1'b1, 32'h1000);
    end
`ifdef NPC_RAS_EN
    ret_lit = 32'h604;
`else
    ret_lit = 32'h720;
`endif
    cyc("ret_after_stall", 1'b1, 3'd5, 1'b0, 32'h0, 32'h720, 32'h600, 1'b0, 1'b1, ret_lit);

    // Reserved type behaves as sequential.
    cyc("reserved", 1'b1, 3'd7, 1'b1, 32'h40, 32'h0, 32'h700, 1'b0, 1'b1, 32'h704);

    // HALT, then further requests are ignored.
    cyc("halt",       1'b1, 3'd6, 1'b0, 32'h0, 32'h0, 32'h800, 1'b0, 1'b1, 32'h804);
    cyc("halt_seq",   1'b1, 3'd0, 1'b0, 32'h0, 32'h0, 32'h900, 1'b0, 1'b1, 32'h804);
    cyc("halt_jreg",  1'b1, 3'd3, 1'b0, 32'h0, 32'hA00, 32'h900, 1'b0, 1'b1, 32'h804);

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cyc("reboot",    1'b1, 3'd2, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b1, BOOT);
    cyc("reboot_br", 1'b1, 3'd1, 1'b1, 32'h10, 32'h0, 32'h20, 1'b0, 1'b1, 32'h34);

    if (sb.size() != 0) begin
      chk("sb_drained", 32'(sb.size()), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
